// File: rtl/im_loader_pkg.sv
// Shared types and constants for the UART instruction-memory loader.
// Holds the frame FSM states, the sync byte and the baud divider helper.
package im_loader_pkg;

  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CSUM, ERR} state_e;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 2-FF synchronizer, mid-bit sampling, glitch-rejecting start detect.
// Emits a one-cycle rx_valid_o with the byte, or frame_err_o when the stop bit is low.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx_i,
  output logic       rx_valid_o,
  output logic [7:0] rx_data_o,
  output logic       frame_err_o
);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_e;

  localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);

  rx_state_e   state_q, state_d;
  logic [1:0]  sync_q;
  logic        prev_q;
  logic [15:0] cnt_q;
  logic [2:0]  bit_q;
  logic [7:0]  shift_q;
  logic        rx_s;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= RX_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_IDLE:  if (prev_q && !rx_s) state_d = RX_START;
      // A start bit that is high again at half-bit was a glitch.
      RX_START: if (cnt_q == HALF_M1) state_d = rx_s ? RX_IDLE : RX_BITS;
      RX_BITS:  if (cnt_q == FULL_M1 && bit_q == 3'd7) state_d = RX_STOP;
      RX_STOP:  if (cnt_q == FULL_M1) state_d = RX_IDLE;
      default:  state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      sync_q <= {sync_q[0], rx_i};
      prev_q <= rx_s;
      if (state_q == RX_IDLE || state_d != state_q || cnt_q == FULL_M1) cnt_q <= '0;
      else                                                              cnt_q <= cnt_q + 16'd1;
      if (state_q == RX_START) bit_q <= '0;
      if (state_q == RX_BITS && cnt_q == FULL_M1) begin
        shift_q <= {rx_s, shift_q[7:1]};
        bit_q   <= bit_q + 3'd1;
      end
    end
  end

  always_comb begin
    rx_valid_o  = (state_q == RX_STOP) && (cnt_q == FULL_M1) && rx_s;
    frame_err_o = (state_q == RX_STOP) && (cnt_q == FULL_M1) && !rx_s;
    rx_data_o   = shift_q;
  end

endmodule

// File: rtl/im_uart_loader.sv
// Loads a program into instruction memory from a UART frame: A5, LEN_L, LEN_H, 4*N data, CSUM.
// Holds the CPU in reset from sync byte until a good checksum; errors keep it held.
module im_uart_loader #(
  parameter int CLK_HZ       = 100_000_000,
  parameter int BAUD         = 115_200,
  parameter int ADDR_W       = 8,
  parameter int TIMEOUT_CLKS = 10_000_000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              uart_rx_i,
  output logic              im_we_o,
  output logic [ADDR_W-1:0] im_addr_o,
  output logic [31:0]       im_wdata_o,
  output logic              cpu_hold_o,
  output logic              load_done_o,
  output logic              load_err_o,
  output logic [ADDR_W:0]   words_loaded_o
);
  import im_loader_pkg::*;

  localparam int                CPB       = clks_per_bit(CLK_HZ, BAUD);
  localparam int                TMO_W     = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CLKS - 1);
  localparam logic [16:0]       MAX_WORDS = 17'(2 ** ADDR_W);

  logic        rx_valid, frame_err;
  logic [7:0]  rx_data;

  state_e            state_q, state_d;
  logic [7:0]        len_lo_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   wl_q;
  logic [23:0]       word_q;
  logic [1:0]        byte_q;
  logic [7:0]        csum_q;
  logic [TMO_W-1:0]  tmo_q;
  logic              hold_q, err_q, done_q, we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [16:0]       len_full;
  logic              in_frame;

  uart_rx_byte #(.CLKS_PER_BIT(CPB)) u_rx (
    .clk         (clk),
    .rstn        (rstn),
    .rx_i        (uart_rx_i),
    .rx_valid_o  (rx_valid),
    .rx_data_o   (rx_data),
    .frame_err_o (frame_err)
  );

  assign len_full = {1'b0, rx_data, len_lo_q};
  assign in_frame = state_q inside {LEN0, LEN1, DATA, CSUM};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (rx_valid && rx_data == SYNC_BYTE) state_d = LEN0;
      LEN0: if (rx_valid) state_d = LEN1;
      LEN1: if (rx_valid) begin
        if (len_full > MAX_WORDS)   state_d = ERR;
        else if (len_full == 17'd0) state_d = CSUM;
        else                        state_d = DATA;
      end
      // Leave DATA only after the last write pulse so im_we_o stays inside DATA.
      DATA: if (we_q && wl_q == len_q) state_d = CSUM;
      CSUM: if (rx_valid) state_d = (rx_data == csum_q) ? IDLE : ERR;
      ERR:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (in_frame && (frame_err || tmo_q == TMO_LAST)) state_d = ERR;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      len_lo_q <= '0;
      len_q    <= '0;
      wl_q     <= '0;
      word_q   <= '0;
      byte_q   <= '0;
      csum_q   <= '0;
      tmo_q    <= '0;
      hold_q   <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      done_q <= 1'b0;
      we_q   <= 1'b0;
      if (in_frame && !rx_valid) tmo_q <= tmo_q + TMO_W'(1);
      else                       tmo_q <= '0;
      case (state_q)
        IDLE: if (rx_valid && rx_data == SYNC_BYTE) begin
          hold_q <= 1'b1;
          err_q  <= 1'b0;
          wl_q   <= '0;
          csum_q <= '0;
          byte_q <= '0;
        end
        LEN0: if (rx_valid) begin
          len_lo_q <= rx_data;
          csum_q   <= csum_q ^ rx_data;
        end
        LEN1: if (rx_valid) begin
          len_q  <= len_full[ADDR_W:0];
          csum_q <= csum_q ^ rx_data;
        end
        DATA: if (rx_valid) begin
          csum_q <= csum_q ^ rx_data;
          word_q <= {rx_data, word_q[23:8]};
          byte_q <= byte_q + 2'd1;
          if (byte_q == 2'd3) begin
            we_q    <= 1'b1;
            addr_q  <= wl_q[ADDR_W-1:0];
            wdata_q <= {rx_data, word_q};
            wl_q    <= wl_q + (ADDR_W + 1)'(1);
          end
        end
        CSUM: if (rx_valid && rx_data == csum_q) begin
          done_q <= 1'b1;
          hold_q <= 1'b0;
        end
        ERR:  err_q <= 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    im_we_o        = we_q && (state_q == DATA);
    im_addr_o      = addr_q;
    im_wdata_o     = wdata_q;
    cpu_hold_o     = hold_q;
    load_done_o    = done_q;
    load_err_o     = err_q;
    words_loaded_o = wl_q;
  end

endmodule

// File: tb/tb_im_uart_loader.sv
// Self-checking bench for im_uart_loader: table of frames plus hand-written corner sequences.
// Expected IM writes are queued from the stimulus bytes and popped as the DUT writes.
module tb_im_uart_loader;
  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       uart_rx = 1'b1;
  logic       im_we, hold, done, err;
  logic [7:0] im_addr;
  logic [31:0] im_wdata;
  logic [8:0] words;

  im_uart_loader #(.CLK_HZ(1_000_000), .BAUD(100_000), .ADDR_W(8), .TIMEOUT_CLKS(500)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .uart_rx_i      (uart_rx),
    .im_we_o        (im_we),
    .im_addr_o      (im_addr),
    .im_wdata_o     (im_wdata),
    .cpu_hold_o     (hold),
    .load_done_o    (done),
    .load_err_o     (err),
    .words_loaded_o (words)
  );

  always #5 clk = ~clk;

  typedef struct {
    int first; int skip; int n; int csum_mode;
    int exp_done; int exp_err; int exp_words; int exp_hold;
  } vec_t;

  vec_t        vecs [4];
  logic [7:0]  pool [$];
  logic [39:0] exp_q [$];
  logic [39:0] exp_w;
  int checks = 0, failures = 0, done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Scoreboard: every write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (im_we) begin
      checks++;
      $display("write addr=%0d data=%08h", im_addr, im_wdata);
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write actual=%0h:%08h required=none", im_addr, im_wdata);
      end else begin
        exp_w = exp_q.pop_front();
        if ({im_addr, im_wdata} !== exp_w) begin
          failures++;
          $display("FAIL write actual=%0h:%08h required=%0h:%08h",
                   im_addr, im_wdata, exp_w[39:32], exp_w[31:0]);
        end
      end
    end
  end

  task automatic add_bytes(input logic [95:0] v, input int n);
    for (int i = 0; i < n; i++) pool.push_back(v[8*(n-1-i) +: 8]);
  endtask

  task automatic send_bit(input logic b);
    uart_rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_list(input logic [95:0] v, input int n);
    for (int i = 0; i < n; i++) send_byte(v[8*(n-1-i) +: 8], 1'b1);
  endtask

  task automatic check_queue_empty(input string name);
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic run_vec(input int k);
    vec_t v;
    logic [7:0] cs;
    int base, b;
    v = vecs[k];
    cs = 8'h00;
    done_cnt = 0;
    base = v.first + v.skip;
    for (int w = 0; w < v.exp_words; w++) begin
      b = base + 3 + 4 * w;
      exp_q.push_back({8'(w), pool[b+3], pool[b+2], pool[b+1], pool[b]});
    end
    for (int i = 0; i < v.n; i++) begin
      send_byte(pool[v.first+i], 1'b1);
      if (i > v.skip) cs = cs ^ pool[v.first+i];
      if (v.skip > 0 && i == v.skip - 1) check($sformatf("v%0d_hold_before_sync", k), 32'(hold), 32'd0);
      if (i == v.skip) check($sformatf("v%0d_hold_after_sync", k), 32'(hold), 32'd1);
    end
    if (v.csum_mode != 0) send_byte((v.csum_mode == 2) ? (cs ^ 8'h01) : cs, 1'b1);
    repeat (20) @(negedge clk);
    check($sformatf("v%0d_done", k), 32'(done_cnt), 32'(v.exp_done));
    check($sformatf("v%0d_err", k), 32'(err), 32'(v.exp_err));
    check($sformatf("v%0d_words", k), 32'(words), 32'(v.exp_words));
    check($sformatf("v%0d_hold", k), 32'(hold), 32'(v.exp_hold));
    check_queue_empty($sformatf("v%0d_missing_writes", k));
    $display("vector %0d: done=%0d err=%0b words=%0d hold=%0b", k, done_cnt, err, words, hold);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    add_bytes(96'hA5_02_00_13_00_50_00_93_00_10_00, 11);
    add_bytes(96'h00_FF_5A_A5_00_00, 6);
    add_bytes(96'hA5_01_01, 3);
    vecs[0] = '{first: 0,  skip: 0, n: 11, csum_mode: 1, exp_done: 1, exp_err: 0, exp_words: 2, exp_hold: 0};
    vecs[1] = '{first: 11, skip: 3, n: 6,  csum_mode: 1, exp_done: 1, exp_err: 0, exp_words: 0, exp_hold: 0};
    vecs[2] = '{first: 0,  skip: 0, n: 11, csum_mode: 2, exp_done: 0, exp_err: 1, exp_words: 2, exp_hold: 1};
    vecs[3] = '{first: 17, skip: 0, n: 3,  csum_mode: 0, exp_done: 0, exp_err: 1, exp_words: 0, exp_hold: 1};

    repeat (4) @(negedge clk);
    check("rst_we", 32'(im_we), 32'd0);
    check("rst_hold", 32'(hold), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_words", 32'(words), 32'd0);
    rstn = 1'b1;
    repeat (5) @(negedge clk);

    for (int k = 0; k < 4; k++) run_vec(k);

    // Stall mid-DATA: timeout must abort without writing, then a good frame recovers.
    send_list(96'hA5_02_00_13_00, 5);
    repeat (600) @(negedge clk);
    check("tmo_err", 32'(err), 32'd1);
    check("tmo_hold", 32'(hold), 32'd1);
    check("tmo_words", 32'(words), 32'd0);
    check_queue_empty("tmo_writes");
    run_vec(0);

    // Async reset after the first word of a frame.
    exp_q.push_back({8'd0, 32'h00500013});
    send_list(96'hA5_02_00_13_00_50_00_93_00, 9);
    check("pre_rst_hold", 32'(hold), 32'd1);
    check("pre_rst_words", 32'(words), 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("async_hold", 32'(hold), 32'd0);
    check("async_words", 32'(words), 32'd0);
    check("async_we", 32'(im_we), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    send_list(96'h10_00, 2);
    repeat (20) @(negedge clk);
    check("post_rst_hold", 32'(hold), 32'd0);
    check("post_rst_words", 32'(words), 32'd0);
    check_queue_empty("post_rst_writes");

    // Bad stop bit inside DATA.
    send_list(96'hA5_02_00, 3);
    send_byte(8'h13, 1'b0);
    repeat (20) @(negedge clk);
    send_list(96'h00_50_00, 3);
    repeat (20) @(negedge clk);
    check("stop_err", 32'(err), 32'd1);
    check("stop_hold", 32'(hold), 32'd1);
    check("stop_words", 32'(words), 32'd0);
    check_queue_empty("stop_writes");

    // One-clock low glitch inside an empty frame must not become a byte.
    done_cnt = 0;
    send_list(96'hA5_00_00, 3);
    uart_rx = 1'b0;
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (30) @(negedge clk);
    send_byte(8'h00, 1'b1);
    repeat (20) @(negedge clk);
    check("glitch_done", 32'(done_cnt), 32'd1);
    check("glitch_err", 32'(err), 32'd0);
    check("glitch_hold", 32'(hold), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
